// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store master: access-size codes,
// FSM state codes and the byte-mask/byte-count helpers.
package lsu_pkg;

  // Access-size encodings on req_size (2'b11 behaves like a word).
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Right-justified byte mask for an access of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 4'b0001;
      SZ_H:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational lane steering: places store data and strobes onto
// the byte lanes of the low/high word, and extracts plus extends load data
// from the (possibly split) pair of words read back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  lo_strb,
  output logic [3:0]  hi_strb,
  output logic [31:0] lo_data,
  output logic [31:0] hi_data,
  output logic [31:0] ld_data
);

  logic [7:0]  s8;
  logic [63:0] d64;
  logic [31:0] m;

  // Shift strobes/data up by the byte offset across a 64-bit window and
  // shift the merged read words down by the same offset.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    s8      = {4'b0000, size_mask(size)} << off;
    d64     = {32'b0, wdata} << {off, 3'b000};
    m       = 32'({hi_word, lo_word} >> {off, 3'b000});
    lo_strb = s8[3:0];
    hi_strb = s8[7:4];
    lo_data = d64[31:0];
    hi_data = d64[63:32];
    case (size)
      SZ_B:    ld_data = is_unsigned ? {24'b0, m[7:0]}  : {{24{m[7]}}, m[7:0]};
      SZ_H:    ld_data = is_unsigned ? {16'b0, m[15:0]} : {{16{m[15]}}, m[15:0]};
      default: ld_data = m;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// CPU-side load/store master. Takes one request over valid/ready, performs
// one or two word accesses on the byte-strobed memory port (two when the
// access straddles a word boundary) and returns a one-cycle response.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int AW   = 9,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [3:0]      mem_strb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  logic [1:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] lo_word_q, lo_word_d;
  logic [XLEN-1:0] hi_word_q, hi_word_d;

  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   next_addr;
  logic [3:0]      lo_strb, hi_strb;
  logic [XLEN-1:0] lo_data, hi_data, ld_data;

  // First word of the access and the following word, wrapping at the top.
  assign base_addr = {addr_q[AW-1:2], 2'b00};
  assign next_addr = base_addr + AW'(4);

  lsu_lane_align u_lane_align (
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .lo_word     (lo_word_q),
    .hi_word     (hi_word_q),
    .lo_strb     (lo_strb),
    .hi_strb     (hi_strb),
    .lo_data     (lo_data),
    .hi_data     (hi_data),
    .ld_data     (ld_data)
  );

  // Next-state and request/read-data capture.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    split_d   = split_q;
    lo_word_d = lo_word_q;
    hi_word_d = hi_word_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          split_d   = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
          hi_word_d = '0;  // unsplit loads merge against zero
          state_d   = ST_ACC0;
        end
      end
      ST_ACC0: begin
        if (!we_q) lo_word_d = mem_rdata;
        state_d = split_q ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        if (!we_q) hi_word_d = mem_rdata;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-port and response outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_strb  = 4'b0000;
    mem_wdata = '0;
    case (state_q)
      ST_ACC0: begin
        mem_addr = base_addr;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_strb  = lo_strb;
          mem_wdata = lo_data;
        end else begin
          mem_strb  = 4'b1111;
        end
      end
      ST_ACC1: begin
        mem_addr = next_addr;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_strb  = hi_strb;
          mem_wdata = hi_data;
        end else begin
          mem_strb  = 4'b1111;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? '0 : ld_data;
      end
      default: ;
    endcase
  end

  // State and request registers; reset returns to IDLE and aborts any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      split_q   <= 1'b0;
      lo_word_q <= '0;
      hi_word_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      split_q   <= split_d;
      lo_word_q <= lo_word_d;
      hi_word_q <= hi_word_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 128-word byte-strobed memory
// model, a write log and a response-pulse counter.
module tb_lsu_mem_master;

  localparam int AW = 9;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    s;
    logic [31:0]   d;
  } wr_t;

  logic [31:0] mem [128];
  wr_t         wr_q[$];
  int          rsp_cnt;
  logic        preload;
  int          checks;
  int          errors;

  lsu_mem_master #(.AW(AW), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_strb     (mem_strb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[AW-1:2]];

  // Memory model: preload, then byte-strobed writes logged in order.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[8]   <= 32'h8001_1234;
      mem[127] <= 32'hAB00_0000;
      mem[0]   <= 32'h0000_00CD;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_strb[b]) mem[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_q.push_back('{a: mem_addr, s: mem_strb, d: mem_wdata});
    end
  end

  // Response pulse counter.
  always @(posedge clk or negedge reset) begin
    if (!reset) rsp_cnt <= rsp_cnt;
    else if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request; returns response latency (-1 on timeout), load data and
  // the memory address/strobe seen in the first two access cycles.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic [AW-1:0] a0, output logic [AW-1:0] a1,
                        output logic [3:0] s0);
    lat   = -1;
    rdata = 32'hxxxx_xxxx;
    a0    = '0;
    a1    = '0;
    s0    = '0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0;
        a0 = mem_addr;
        s0 = mem_strb;
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      end
      if (n == 2) a1 = mem_addr;
      if (rsp_valid) begin
        lat   = n;
        rdata = rsp_rdata;
      end
    end
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
  endtask

  int            lat;
  int            nw;
  int            nr;
  logic [31:0]   rd;
  logic [AW-1:0] a0, a1;
  logic [3:0]    s0;

  initial begin
    checks       = 0;
    errors       = 0;
    rsp_cnt      = 0;
    reset        = 1'b0;
    preload      = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    @(posedge clk);
    #1 preload = 1'b0;

    // Reset values.
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr",  {23'b0, mem_addr}, 32'h0);
    check("rst_mem_strb",  {28'b0, mem_strb}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;

    // Reset during ACC1 of a split store aborts the second write.
    nw = wr_q.size();
    nr = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 9'h02E;
    req_wdata = 32'h5566_7788;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_acc0_addr", {23'b0, mem_addr}, 32'h02C);
    @(negedge clk);
    check("abort_acc1_addr", {23'b0, mem_addr}, 32'h030);
    reset = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_writes", wr_q.size() - nw, 32'd1);
    check("abort_no_rsp", rsp_cnt - nr, 32'd0);
    check("abort_word_2c", mem[11], 32'h7788_0000);
    check("abort_word_30", mem[12], 32'h0);

    // Aligned word store.
    nw = wr_q.size();
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, lat, rd, a0, a1, s0);
    check("sw_latency", lat, 32'd2);
    check("sw_rdata", rd, 32'h0);
    check("sw_writes", wr_q.size() - nw, 32'd1);
    check("sw_addr", {23'b0, wr_q[nw].a}, 32'h010);
    check("sw_strb", {28'b0, wr_q[nw].s}, 32'hF);
    check("sw_wdata", wr_q[nw].d, 32'hDEAD_BEEF);

    // Byte store to lane 3, then signed/unsigned byte loads.
    nw = wr_q.size();
    do_req(1'b1, 2'b00, 1'b0, 9'h013, 32'h0000_00A5, lat, rd, a0, a1, s0);
    check("sb_latency", lat, 32'd2);
    check("sb_strb", {28'b0, wr_q[nw].s}, 32'h8);
    check("sb_wdata", wr_q[nw].d, 32'hA500_0000);
    check("sb_word", mem[4], 32'hA5AD_BEEF);
    do_req(1'b0, 2'b00, 1'b0, 9'h013, 32'h0, lat, rd, a0, a1, s0);
    check("lb_latency", lat, 32'd2);
    check("lb_addr", {23'b0, a0}, 32'h010);
    check("lb_strb", {28'b0, s0}, 32'hF);
    check("lb_signed", rd, 32'hFFFF_FFA5);
    do_req(1'b0, 2'b00, 1'b1, 9'h013, 32'h0, lat, rd, a0, a1, s0);
    check("lbu_unsigned", rd, 32'h0000_00A5);

    // Half loads from the upper half of word 0x20.
    do_req(1'b0, 2'b01, 1'b0, 9'h022, 32'h0, lat, rd, a0, a1, s0);
    check("lh_latency", lat, 32'd2);
    check("lh_signed", rd, 32'hFFFF_8001);
    do_req(1'b0, 2'b01, 1'b1, 9'h022, 32'h0, lat, rd, a0, a1, s0);
    check("lhu_unsigned", rd, 32'h0000_8001);

    // Split word store at 0x1E and reload.
    nw = wr_q.size();
    do_req(1'b1, 2'b10, 1'b0, 9'h01E, 32'h1122_3344, lat, rd, a0, a1, s0);
    check("ssw_latency", lat, 32'd3);
    check("ssw_writes", wr_q.size() - nw, 32'd2);
    check("ssw_addr0", {23'b0, wr_q[nw].a}, 32'h01C);
    check("ssw_strb0", {28'b0, wr_q[nw].s}, 32'hC);
    check("ssw_wdata0", wr_q[nw].d, 32'h3344_0000);
    check("ssw_addr1", {23'b0, wr_q[nw+1].a}, 32'h020);
    check("ssw_strb1", {28'b0, wr_q[nw+1].s}, 32'h3);
    check("ssw_wdata1", wr_q[nw+1].d, 32'h0000_1122);
    do_req(1'b0, 2'b10, 1'b0, 9'h01E, 32'h0, lat, rd, a0, a1, s0);
    check("slw_latency", lat, 32'd3);
    check("slw_rdata", rd, 32'h1122_3344);

    // Split half load at the top byte wraps to word 0.
    do_req(1'b0, 2'b01, 1'b0, 9'h1FF, 32'h0, lat, rd, a0, a1, s0);
    check("wrap_latency", lat, 32'd3);
    check("wrap_addr0", {23'b0, a0}, 32'h1FC);
    check("wrap_addr1", {23'b0, a1}, 32'h000);
    check("wrap_signed", rd, 32'hFFFF_CDAB);
    do_req(1'b0, 2'b01, 1'b1, 9'h1FF, 32'h0, lat, rd, a0, a1, s0);
    check("wrap_unsigned", rd, 32'h0000_CDAB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
